// File: rtl/stack_unit_if.sv
// ---------------------------------------------------------------------------
// stack_unit_if -- request/response bundle for stack_unit.
//
// Parameters
//   WIDTH  data word width in bits
//   DEPTH  number of stack entries (power of two, >= 2)
//
// Signals
//   push     request: write din onto the top of the stack
//   pop      request: read the top entry into dout and remove it
//   tos      request: read the top entry into dout, keep it
//   err_clr  request: clear the sticky overflow/underflow flags
//   din      data to push
//   dout     registered read data, held until the next successful read
//   count    number of stored entries, 0..DEPTH
//   empty    count == 0
//   full     count == DEPTH
//   overflow   sticky, set by a rejected push
//   underflow  sticky, set by a rejected pop or tos
//
// Modports
//   master  drives the requests and observes the status (bench / client)
//   slave   the stack itself
// ---------------------------------------------------------------------------
interface stack_unit_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic             tos;
    logic             err_clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, tos, err_clr, din,
        input  dout, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, tos, err_clr, din,
        output dout, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_unit.sv
// ---------------------------------------------------------------------------
// stack_unit -- LIFO stack with registered read port and sticky error flags.
//
// Parameters
//   WIDTH  data word width in bits
//   DEPTH  number of entries (power of two, >= 2); the interface instance
//          connected to bus must be built with the same WIDTH/DEPTH
//
// Ports
//   clk  single clock, all state changes on the rising edge
//   rst  synchronous active-high reset
//   bus  stack_unit_if.slave: push/pop/tos/err_clr/din requests in,
//        dout/count/empty/full/overflow/underflow status out
//
// Every request sampled at a rising edge takes full effect at that edge.
// Reads use rd = pop | tos, with pop taking precedence when both are high.
// push together with pop on a non-empty stack replaces the top entry and
// returns its old value, and is allowed even when full.
// ---------------------------------------------------------------------------
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    stack_unit_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage and architectural state. mem has no reset: after reset sp is 0
    // so nothing stale can be read before it is overwritten by a push.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [WIDTH-1:0] dout_q;
    logic             overflow_q;
    logic             underflow_q;

    // Status derived from the stack pointer
    logic is_empty;
    logic is_full;

    // Decoded per-cycle actions
    logic             rd;
    logic             do_read;
    logic             replace;
    logic             push_ok;
    logic             pop_ok;
    logic             ovf_evt;
    logic             unf_evt;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic [CW-1:0]    sp_next;

    assign is_empty = (sp == '0);
    assign is_full  = (sp == CW'(DEPTH));

    // Index of the top entry. Only meaningful while sp is 1..DEPTH; the low
    // AW bits of DEPTH are zero so the modular subtraction yields DEPTH-1.
    assign top_idx = sp[AW-1:0] - AW'(1);

    always_comb begin
        rd      = 1'b0;
        do_read = 1'b0;
        replace = 1'b0;
        push_ok = 1'b0;
        pop_ok  = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = sp[AW-1:0];
        sp_next = sp;

        rd = bus.pop | bus.tos;

        // Any read (pop or tos) is honoured whenever there is an entry,
        // independently of what happens to a simultaneous push.
        do_read = rd & ~is_empty;
        unf_evt = rd &  is_empty;

        // push+pop on a non-empty stack overwrites the top in place; sp
        // stays put, so fullness does not matter.
        replace = bus.push & bus.pop & ~is_empty;

        // Every other push is an ordinary append, gated only by fullness.
        // On an empty stack push+pop falls through here: the pop is the
        // rejected part and the push proceeds.
        push_ok = bus.push & ~replace & ~is_full;
        ovf_evt = bus.push & ~replace &  is_full;

        // A pop without push shrinks the stack.
        pop_ok  = bus.pop & ~bus.push & ~is_empty;

        wr_en   = replace | push_ok;
        wr_idx  = replace ? top_idx : sp[AW-1:0];

        if (push_ok) begin
            sp_next = sp + CW'(1);
        end else if (pop_ok) begin
            sp_next = sp - CW'(1);
        end
    end

    // Array writes: ignored while rst is high, never cleared.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_idx] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp          <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp <= sp_next;
            // The read sees the pre-edge array, so a replace returns the
            // old top while the new value lands in the same slot.
            if (do_read) begin
                dout_q <= mem[top_idx];
            end
            // A new error event in the clearing cycle keeps the flag set.
            overflow_q  <= ovf_evt | (overflow_q  & ~bus.err_clr);
            underflow_q <= unf_evt | (underflow_q & ~bus.err_clr);
        end
    end

    assign bus.dout      = dout_q;
    assign bus.count     = sp;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_stack_unit -- self-checking bench for stack_unit.
//
// A queue-based reference stack is updated on each rising edge from the same
// request inputs; a compare process checks every DUT output against it on
// each falling edge. Directed sequences with literal expectations run first,
// then a long stretch of biased random traffic.
// ---------------------------------------------------------------------------
module tb_stack_unit;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stack_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        checks_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] stk [$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_ovf  = 1'b0;
    logic             m_unf  = 1'b0;

    always @(posedge clk) begin
        logic ov;
        logic un;
        ov = 1'b0;
        un = 1'b0;
        if (rst) begin
            stk.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            if (bus.pop && bus.push) begin
                if (stk.size() > 0) begin
                    m_dout = stk[stk.size()-1];
                    stk[stk.size()-1] = bus.din;
                end else begin
                    un = 1'b1;
                    stk.push_back(bus.din);
                end
            end else if (bus.pop) begin
                if (stk.size() > 0) m_dout = stk.pop_back();
                else                un = 1'b1;
            end else begin
                if (bus.tos) begin
                    if (stk.size() > 0) m_dout = stk[stk.size()-1];
                    else                un = 1'b1;
                end
                if (bus.push) begin
                    if (stk.size() < DEPTH) stk.push_back(bus.din);
                    else                    ov = 1'b1;
                end
            end
            m_ovf = ov | (m_ovf & ~bus.err_clr);
            m_unf = un | (m_unf & ~bus.err_clr);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checks_on) begin
            chk("dout",      32'(bus.dout),      32'(m_dout));
            chk("count",     32'(bus.count),     32'(stk.size()));
            chk("empty",     32'(bus.empty),     32'(stk.size() == 0));
            chk("full",      32'(bus.full),      32'(stk.size() == DEPTH));
            chk("overflow",  32'(bus.overflow),  32'(m_ovf));
            chk("underflow", 32'(bus.underflow), 32'(m_unf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic r, input logic p, input logic q, input logic t,
                      input logic c, input logic [WIDTH-1:0] d);
        rst         = r;
        bus.push    = p;
        bus.pop     = q;
        bus.tos     = t;
        bus.err_clr = c;
        bus.din     = d;
        @(negedge clk);
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d); op(0, 1, 0, 0, 0, d); endtask
    task automatic do_pop();                           op(0, 0, 1, 0, 0, '0); endtask
    task automatic do_tos();                           op(0, 0, 0, 1, 0, '0); endtask
    task automatic do_clr();                           op(0, 0, 0, 0, 1, '0); endtask

    initial begin
        logic [WIDTH-1:0] rd;

        rst = 1'b1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0;
        bus.err_clr = 1'b0; bus.din = '0;

        // Reset with a push asserted: push must be ignored.
        op(1, 1, 0, 0, 0, 8'h5A);
        checks_on = 1'b1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full",  32'(bus.full),  0);
        chk("rst_dout",  32'(bus.dout),  0);
        chk("rst_flags", {30'd0, bus.overflow, bus.underflow}, 0);

        // LIFO order
        do_push(8'h11); do_push(8'h22); do_push(8'h33);
        chk("lifo_count3", 32'(bus.count), 3);
        do_pop(); chk("lifo_pop1", 32'(bus.dout), 32'h33); chk("lifo_cnt2", 32'(bus.count), 2);
        do_pop(); chk("lifo_pop2", 32'(bus.dout), 32'h22);
        do_pop(); chk("lifo_pop3", 32'(bus.dout), 32'h11);
        chk("lifo_cnt0", 32'(bus.count), 0); chk("lifo_empty", 32'(bus.empty), 1);

        // Peek without removal
        do_push(8'h05);
        do_tos(); chk("tos1", 32'(bus.dout), 32'h05); chk("tos1_cnt", 32'(bus.count), 1);
        do_tos(); chk("tos2", 32'(bus.dout), 32'h05); chk("tos2_cnt", 32'(bus.count), 1);
        do_pop(); chk("tos_pop", 32'(bus.dout), 32'h05); chk("tos_pop_cnt", 32'(bus.count), 0);

        // Fill, overflow, pop returns the last accepted value
        for (int i = 0; i < DEPTH; i++) do_push(WIDTH'(8'h40 + i));
        chk("fill_full", 32'(bus.full), 1);
        do_push(8'hAA);
        chk("ovf_flag", 32'(bus.overflow), 1);
        chk("ovf_count", 32'(bus.count), DEPTH);
        do_pop();
        chk("ovf_pop", 32'(bus.dout), 32'h40 + DEPTH - 1);
        do_clr();
        chk("ovf_clr", 32'(bus.overflow), 0);
        for (int i = 0; i < DEPTH - 1; i++) do_pop();
        chk("drain_dout", 32'(bus.dout), 32'h40);

        // Underflow, held dout, clear, set-wins-over-clear
        do_pop();
        chk("unf_flag", 32'(bus.underflow), 1);
        chk("unf_dout", 32'(bus.dout), 32'h40);
        chk("unf_count", 32'(bus.count), 0);
        do_clr();
        chk("unf_clr", 32'(bus.underflow), 0);
        op(0, 0, 1, 0, 1, '0);
        chk("unf_set_wins", 32'(bus.underflow), 1);
        do_clr();

        // Replace-top
        do_push(8'h01); do_push(8'h02);
        op(0, 1, 1, 0, 0, 8'h09);
        chk("rep_dout", 32'(bus.dout), 32'h02); chk("rep_count", 32'(bus.count), 2);
        do_pop(); chk("rep_pop", 32'(bus.dout), 32'h09);
        do_pop(); chk("rep_pop2", 32'(bus.dout), 32'h01);

        // Push with tos on empty: tos rejected, push accepted
        op(0, 1, 0, 1, 0, 8'h77);
        chk("pt_empty_unf", 32'(bus.underflow), 1);
        chk("pt_empty_cnt", 32'(bus.count), 1);
        chk("pt_empty_dout", 32'(bus.dout), 32'h01);
        do_tos(); chk("pt_empty_tos", 32'(bus.dout), 32'h77);

        // Mid-sequence reset with push asserted
        do_push(8'hA1); do_push(8'hA2);
        op(1, 1, 0, 0, 0, 8'hEE);
        chk("mrst_count", 32'(bus.count), 0);
        chk("mrst_dout",  32'(bus.dout), 0);
        chk("mrst_flags", {30'd0, bus.overflow, bus.underflow}, 0);
        do_tos();
        chk("mrst_tos_unf", 32'(bus.underflow), 1);

        // Biased random traffic: alternating fill-heavy and drain-heavy phases
        for (int n = 0; n < 4000; n++) begin
            logic hi;
            hi = ((n / 64) % 2) == 0;
            rd = WIDTH'($urandom);
            op($urandom_range(299) == 0,
               $urandom_range(99) < (hi ? 75 : 30),
               $urandom_range(99) < (hi ? 20 : 55),
               $urandom_range(99) < 25,
               $urandom_range(15) == 0,
               rd);
        end

        op(0, 0, 0, 0, 0, '0);
        checks_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
